matrix_ram: RTL and testbench
=============================

# matrix_ram

Synchronous single-port RAM holding matrix rows: each address stores one row of eight DATA_WIDTH-bit elements, and each element is individually selected by a 3-bit lane index. It is the storage element of the matrix-multiplication datapath, where the sequencer writes matrix operands element by element and reads them back element by element. Active-low chip-enable and write-enable strobes make it a drop-in for the codebase's RAM style.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one matrix element
- ADDRESS_BITS, 2, row address width; depth = 2**ADDRESS_BITS rows

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  reset, synchronous, active-high: asserted when 1 despite the suffix, which is kept for port-name compatibility
- wren_n  input  1  write enable, active low; 0 = write, 1 = read
- enable_n  input  1  chip enable, active low; 1 = idle
- data  input  DATA_WIDTH  write data
- address  input  ADDRESS_BITS  row select
- byteena  input  3  element (lane) select within the row, 0..7
- out  output  DATA_WIDTH  registered read data

## Operation
- Storage: 2**ADDRESS_BITS rows x 8 lanes x DATA_WIDTH bits; element (a, l) is independent of every other element.
- Priority per rising edge: reset, then idle, then write, then read.
- Reset (rst_n=1 at edge):
  - every element is cleared to 0;
  - out is cleared to 0;
  - enable_n, wren_n, data, address and byteena are ignored.
- Idle (rst_n=0, enable_n=1):
  - no element changes;
  - out holds its value.
- Write (rst_n=0, enable_n=0, wren_n=0):
  - element (address, byteena) <= data;
  - all other elements are unchanged;
  - out holds its previous value (no write-through).
- Read (rst_n=0, enable_n=0, wren_n=1):
  - out <= element (address, byteena).
- All 8 byteena codes are valid. All address codes are valid; there is no out-of-range case, and the address does not auto-increment.
- No X propagation: after reset, every readable element is defined.

## Timing
- Write latency: 1 edge. A read issued on the edge after a write to the same element returns the new value.
- Read latency: 1 edge. out shows the element sampled at edge N immediately after edge N and holds it until the next read or reset.
- Back-to-back reads on consecutive cycles produce one new value per cycle.
- Reset mid-operation: a reset edge overrides a simultaneous write, so the write is lost. out = 0 from that edge onward until the first read after rst_n returns to 0.
- Inputs must be stable around the rising edge; there are no combinational paths from inputs to out.
- Reset value of out: 0.

## Test plan
- Reset, then fill a row:
  - Stimulus: rst_n=1 for one edge, then rst_n=0. With enable_n=0 and wren_n=0, write address 0 at lanes 0..7 with data 11..18, one per edge. Then set wren_n=1 and read lanes 0..7.
  - Required: out = 11..18, each value one edge after its address/lane is presented.
- Full fill and readback:
  - Stimulus: write data 11..42 across addresses 0..3, lanes 0..7 (address-major order). Then read everything back.
  - Required: each (a, l) returns 11 + 8a + l, with no aliasing between rows or lanes.
- Chip enable gating:
  - Stimulus: with enable_n=1 and wren_n=0, present data 0xFF at (2, 5). Then set enable_n=0 and wren_n=1 and read (2, 5).
  - Required: out keeps its prior value while enable_n=1. The read returns the previously written 0x20 (not 0xFF).
- Write does not disturb out:
  - Stimulus: read (1, 3), so out = 0x16. Then write 0xAA to (1, 3). Then read (1, 3).
  - Required: out stays 0x16 during the write edge and becomes 0xAA after the read edge.
- Reset mid-write:
  - Stimulus: assert rst_n=1 on the same edge as a write of 0x55 to (3, 7). Then read (3, 7) and (0, 0).
  - Required: out = 0 right after the reset edge, and both reads return 0.
- Lane independence:
  - Stimulus: write 0x01 to (0, 0) and 0x80 to (0, 7). Then read (0, 0), (0, 7) and (0, 1).
  - Required: reads return 0x01, 0x80 and 0x00 respectively.

Source files
------------

// File: rtl/matrix_ram.sv
// -----------------------------------------------------------------------------
// matrix_ram
//
// Single-port synchronous RAM storing matrix rows. Each row address holds
// eight DATA_WIDTH-bit elements (lanes); one element is written or read per
// clock, selected by {address, byteena}. Read data is registered.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst_n     - synchronous reset, ACTIVE-HIGH despite the name (kept for
//               port-name compatibility); clears every element and out
//   wren_n    - active-low write enable (0 = write, 1 = read)
//   enable_n  - active-low chip enable (1 = idle, nothing changes)
//   data      - write data
//   address   - row select
//   byteena   - lane select within the row, 0..7
//   out       - registered read data
//
// Priority on each rising edge: reset, idle, write, read.
// -----------------------------------------------------------------------------
module matrix_ram #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDRESS_BITS = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wren_n,
   input  logic                    enable_n,
   input  logic [DATA_WIDTH-1:0]   data,
   input  logic [ADDRESS_BITS-1:0] address,
   input  logic [2:0]              byteena,
   output logic [DATA_WIDTH-1:0]   out
);

   localparam int DEPTH = 2 ** ADDRESS_BITS;
   localparam int LANES = 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH][LANES];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH][LANES];
   logic [DATA_WIDTH-1:0] out_q;
   logic [DATA_WIDTH-1:0] out_d;

   // Next-state: a write updates only the addressed element and leaves out
   // untouched (no write-through); a read only loads out.
   always_comb begin
      mem_d = mem_q;
      out_d = out_q;
      if (!enable_n) begin
         if (!wren_n) begin
            mem_d[address][byteena] = data;
         end else begin
            out_d = mem_q[address][byteena];
         end
      end
   end

   // Reset clears the whole array so every element reads back defined; it
   // also wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         mem_q <= '{default: '0};
         out_q <= '0;
      end else begin
         mem_q <= mem_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_matrix_ram.sv
module tb_matrix_ram;

   logic       clk;
   logic       rst_n;
   logic       wren_n;
   logic       enable_n;
   logic [7:0] data;
   logic [1:0] address;
   logic [2:0] byteena;
   logic [7:0] out;

   int tests_run;
   int tests_failed;

   matrix_ram #(
      .DATA_WIDTH  (8),
      .ADDRESS_BITS(2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wren_n  (wren_n),
      .enable_n(enable_n),
      .data    (data),
      .address (address),
      .byteena (byteena),
      .out     (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus helpers: drive at the falling edge, return 1 time unit after
   // the following rising edge so outputs are sampled away from the edge.
   task automatic cycle(input logic r, input logic en_n, input logic we_n,
                        input logic [1:0] a, input logic [2:0] l,
                        input logic [7:0] d);
      @(negedge clk);
      rst_n    = r;
      enable_n = en_n;
      wren_n   = we_n;
      address  = a;
      byteena  = l;
      data     = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [2:0] l, input logic [7:0] d);
      cycle(1'b0, 1'b0, 1'b0, a, l, d);
   endtask

   task automatic rd(input logic [1:0] a, input logic [2:0] l);
      cycle(1'b0, 1'b0, 1'b1, a, l, 8'h00);
   endtask

   task automatic test_reset;
      logic [7:0] exp;
      cycle(1'b1, 1'b0, 1'b0, 2'd1, 3'd1, 8'h77);
      exp = 8'h00;
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL reset_out: got %h expected %h", out, exp);
      end
      rd(2'd2, 3'd3);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL reset_mem_2_3: got %h expected %h", out, exp);
      end
      rd(2'd1, 3'd1);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL reset_ignores_write: got %h expected %h", out, exp);
      end
   endtask

   task automatic test_fill_row;
      logic [7:0] exp;
      for (int l = 0; l < 8; l++) wr(2'd0, 3'(l), 8'(11 + l));
      for (int l = 0; l < 8; l++) begin
         rd(2'd0, 3'(l));
         exp = 8'(11 + l);
         tests_run++;
         if (out !== exp) begin
            tests_failed++;
            $display("FAIL fill_row lane %0d: got %h expected %h", l, out, exp);
         end
      end
   endtask

   task automatic test_full_fill;
      logic [7:0] exp;
      for (int a = 0; a < 4; a++)
         for (int l = 0; l < 8; l++) wr(2'(a), 3'(l), 8'(11 + 8 * a + l));
      for (int a = 0; a < 4; a++)
         for (int l = 0; l < 8; l++) begin
            rd(2'(a), 3'(l));
            exp = 8'(11 + 8 * a + l);
            tests_run++;
            if (out !== exp) begin
               tests_failed++;
               $display("FAIL full_fill (%0d,%0d): got %h expected %h", a, l, out, exp);
            end
         end
   endtask

   task automatic test_enable_gating;
      logic [7:0] exp;
      // out holds the last read, (3,7) = 42
      exp = 8'd42;
      cycle(1'b0, 1'b1, 1'b0, 2'd2, 3'd5, 8'hFF);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL idle_write_holds_out: got %h expected %h", out, exp);
      end
      cycle(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 8'h00);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL idle_read_holds_out: got %h expected %h", out, exp);
      end
      rd(2'd2, 3'd5);
      exp = 8'h20;
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL idle_write_blocked: got %h expected %h", out, exp);
      end
   endtask

   task automatic test_write_no_disturb;
      logic [7:0] exp;
      rd(2'd1, 3'd3);
      exp = 8'h16;
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL nodisturb_pre_read: got %h expected %h", out, exp);
      end
      wr(2'd1, 3'd3, 8'hAA);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL nodisturb_write_edge: got %h expected %h", out, exp);
      end
      rd(2'd1, 3'd3);
      exp = 8'hAA;
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL nodisturb_readback: got %h expected %h", out, exp);
      end
   endtask

   task automatic test_reset_mid_write;
      logic [7:0] exp;
      exp = 8'h00;
      cycle(1'b1, 1'b0, 1'b0, 2'd3, 3'd7, 8'h55);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL midreset_out: got %h expected %h", out, exp);
      end
      cycle(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 8'h00);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL midreset_out_held: got %h expected %h", out, exp);
      end
      rd(2'd3, 3'd7);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL midreset_3_7: got %h expected %h", out, exp);
      end
      rd(2'd0, 3'd0);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL midreset_0_0: got %h expected %h", out, exp);
      end
   endtask

   task automatic test_lane_independence;
      logic [7:0] exp;
      wr(2'd0, 3'd0, 8'h01);
      wr(2'd0, 3'd7, 8'h80);
      rd(2'd0, 3'd0);
      exp = 8'h01;
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL lane_0_0: got %h expected %h", out, exp);
      end
      rd(2'd0, 3'd7);
      exp = 8'h80;
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL lane_0_7: got %h expected %h", out, exp);
      end
      rd(2'd0, 3'd1);
      exp = 8'h00;
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL lane_0_1: got %h expected %h", out, exp);
      end
      rd(2'd1, 3'd0);
      tests_run++;
      if (out !== exp) begin
         tests_failed++;
         $display("FAIL lane_1_0: got %h expected %h", out, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n    = 1'b0;
      enable_n = 1'b1;
      wren_n   = 1'b1;
      address  = '0;
      byteena  = '0;
      data     = '0;
      test_reset();
      test_fill_row();
      test_full_fill();
      test_enable_gating();
      test_write_no_disturb();
      test_reset_mid_write();
      test_lane_independence();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
